// File: rtl/pwm_pkg.sv
// Shared types and helpers for the pwm block and its duty ramp feeder.
package pwm_pkg;

  typedef logic [7:0] duty_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

  localparam int DUTY_FULL_SCALE = 100;

  // Clamp a duty request into [min_v, max_v]; assumes min_v <= max_v.
  function automatic duty_t clamp_duty(input duty_t value, input duty_t min_v, input duty_t max_v);
    duty_t res;
    if (value < min_v) begin
      res = min_v;
    end else if (value > max_v) begin
      res = max_v;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Target handshake from the upstream source and duty strobe towards the pwm block.
interface pwm_duty_ramp_if;
  import pwm_pkg::*;

  duty_t target;
  logic  target_valid;
  logic  target_ready;
  duty_t duty_cycle;
  logic  duty_valid;

  // Upstream source: offers targets, observes the duty stream.
  modport master (
    output target,
    output target_valid,
    input  target_ready,
    input  duty_cycle,
    input  duty_valid
  );

  // Ramp block: accepts targets, produces the duty stream.
  modport slave (
    input  target,
    input  target_valid,
    output target_ready,
    output duty_cycle,
    output duty_valid
  );

endinterface

// File: rtl/pwm_ramp_tick.sv
// Prescaler counting 0..RAMP_DIV-1 while enabled; the wrap cycle is a tick.
// clear_i has priority over en_i and returns the count to 0.
module pwm_ramp_tick #(
  parameter int RAMP_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  if (RAMP_DIV < 1) begin : g_bad_div
    $error("pwm_ramp_tick: RAMP_DIV must be at least 1");
  end

  // Next count: clear, wrap at LAST, or advance; held while disabled.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Tick on the enabled wrap cycle, suppressed when a clear is pending.
  always_comb begin
    tick_o = en_i && !clear_i && (count_q == LAST);
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty slew limiter feeding the pwm block: accepts a clamped target and
// walks the presented duty toward it in STEP increments every RAMP_DIV cycles.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | duty at last accepted target, ready for a new target
//   RAMP_UP   | stepping duty upward, one step per prescaler tick
//   RAMP_DOWN | stepping duty downward, one step per prescaler tick
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int RAMP_DIV   = 1000,
  parameter int STEP       = 1,
  parameter int RESET_DUTY = 20,
  parameter int MIN_DUTY   = 20,
  parameter int MAX_DUTY   = 80
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_i,
  pwm_duty_ramp_if.slave  bus,
  output logic            busy_o,
  output logic            at_target_o
);

  if (!(MIN_DUTY >= 0 && MIN_DUTY <= RESET_DUTY && RESET_DUTY <= MAX_DUTY &&
        MAX_DUTY <= DUTY_FULL_SCALE)) begin : g_bad_limits
    $error("pwm_duty_ramp: need 0 <= MIN_DUTY <= RESET_DUTY <= MAX_DUTY <= 100");
  end

  if (STEP < 1 || STEP > DUTY_FULL_SCALE) begin : g_bad_step
    $error("pwm_duty_ramp: STEP must be in 1..100");
  end

  localparam duty_t RESET_D = duty_t'(RESET_DUTY);
  localparam duty_t MIN_D   = duty_t'(MIN_DUTY);
  localparam duty_t MAX_D   = duty_t'(MAX_DUTY);

  ramp_state_e state_q, state_d;
  duty_t       cur_q, cur_d;
  duty_t       tgt_q, tgt_d;
  logic        dv_q, dv_d;
  logic        at_q, at_d;

  logic        accept;
  logic        tick_en;
  logic        tick;
  duty_t       clamped;
  logic [8:0]  up_sum;
  logic signed [8:0] dn_diff;
  duty_t       up_val;
  duty_t       dn_val;

  assign accept  = bus.target_valid && bus.target_ready;
  assign clamped = clamp_duty(bus.target, MIN_D, MAX_D);
  assign tick_en = (state_q != IDLE) && enable_i;

  // Steps are computed one bit wider (signed downward) so they never wrap;
  // the final step lands exactly on the target.
  assign up_sum  = {1'b0, cur_q} + 9'(STEP);
  assign dn_diff = $signed({1'b0, cur_q}) - $signed(9'(STEP));
  assign up_val  = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[7:0];
  assign dn_val  = (dn_diff < $signed({1'b0, tgt_q})) ? tgt_q : dn_diff[7:0];

  pwm_ramp_tick #(
    .RAMP_DIV (RAMP_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (accept),
    .en_i    (tick_en),
    .tick_o  (tick)
  );

  // State and datapath registers; reset restores the held duty without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= RESET_D;
      tgt_q   <= RESET_D;
      dv_q    <= 1'b0;
      at_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      dv_q    <= dv_d;
      at_q    <= at_d;
    end
  end

  // Next state: pick ramp direction on accept, step on ticks, stop on target.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    dv_d    = 1'b0;
    at_d    = at_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d = clamped;
          if (clamped > cur_q) begin
            state_d = RAMP_UP;
            at_d    = 1'b0;
          end else if (clamped < cur_q) begin
            state_d = RAMP_DOWN;
            at_d    = 1'b0;
          end else begin
            at_d    = 1'b1;
          end
        end
      end
      RAMP_UP: begin
        if (tick) begin
          cur_d = up_val;
          dv_d  = 1'b1;
          if (up_val == tgt_q) begin
            state_d = IDLE;
            at_d    = 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          cur_d = dn_val;
          dv_d  = 1'b1;
          if (dn_val == tgt_q) begin
            state_d = IDLE;
            at_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state and the enable input.
  always_comb begin
    bus.target_ready = (state_q == IDLE) && enable_i;
    busy_o           = (state_q != IDLE);
  end

  assign bus.duty_cycle = cur_q;
  assign bus.duty_valid = dv_q;
  assign at_target_o    = at_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
module tb_pwm_duty_ramp;

  localparam int RAMP_DIV   = 4;
  localparam int STEP       = 5;
  localparam int RESET_DUTY = 20;
  localparam int MIN_DUTY   = 20;
  localparam int MAX_DUTY   = 80;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic busy;
  logic at_target;

  int checks = 0;
  int errors = 0;
  int m_cur  = RESET_DUTY;

  pwm_duty_ramp_if bus_if ();

  pwm_duty_ramp #(
    .RAMP_DIV   (RAMP_DIV),
    .STEP       (STEP),
    .RESET_DUTY (RESET_DUTY),
    .MIN_DUTY   (MIN_DUTY),
    .MAX_DUTY   (MAX_DUTY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .bus         (bus_if.slave),
    .busy_o      (busy),
    .at_target_o (at_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_ref(input int t);
    return (t < MIN_DUTY) ? MIN_DUTY : ((t > MAX_DUTY) ? MAX_DUTY : t);
  endfunction

  // Offer a target, then follow the ramp cycle by cycle. Expected strobes
  // come from the list of duty values between the current and clamped target,
  // one every RAMP_DIV enabled cycles after the accept.
  task automatic run_ramp(input int tgt_in, input int freeze_after, input int freeze_len, input bit poke);
    int seq[$];
    int tc, v, waited, enabled_cnt, idx, freeze_left, guard, limit;
    bit en_edge, frozen_done;
    tc = clamp_ref(tgt_in);
    v = m_cur;
    while (v != tc) begin
      if (tc > v) v = (v + STEP > tc) ? tc : v + STEP;
      else        v = (v - STEP < tc) ? tc : v - STEP;
      seq.push_back(v);
    end
    enable = 1'b1;
    bus_if.target = 8'(tgt_in);
    bus_if.target_valid = 1'b1;
    #1;
    waited = 0;
    while (bus_if.target_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 50) begin
      check("handshake_timeout", 9'd0, 9'd1);
      bus_if.target_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    check("accept_dv", bus_if.duty_valid, 9'd0);
    check("accept_busy", busy, 9'(seq.size() != 0));
    check("accept_at", at_target, 9'(seq.size() == 0));
    check("accept_duty", bus_if.duty_cycle, 9'(m_cur));
    if (!poke) bus_if.target_valid = 1'b0;
    if (seq.size() == 0) begin
      #1;
      check("same_ready", bus_if.target_ready, 9'd1);
      @(posedge clk);
      @(negedge clk);
      check("same_dv", bus_if.duty_valid, 9'd0);
      check("same_busy", busy, 9'd0);
      check("same_duty", bus_if.duty_cycle, 9'(m_cur));
      return;
    end
    enabled_cnt = 0;
    idx = 0;
    guard = 0;
    freeze_left = 0;
    frozen_done = 1'b0;
    if (freeze_after == 0 && freeze_len > 0) begin
      freeze_left = freeze_len;
      frozen_done = 1'b1;
    end
    limit = seq.size() * RAMP_DIV + freeze_len + 20;
    while (idx < seq.size() && guard < limit) begin
      en_edge = (freeze_left == 0);
      if (freeze_left > 0) freeze_left--;
      enable = en_edge;
      if (poke && guard == 2) begin
        bus_if.target = 8'd70;
        bus_if.target_valid = 1'b1;
      end
      if (poke && guard == 6) bus_if.target_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (en_edge) enabled_cnt++;
      if (en_edge && (enabled_cnt % RAMP_DIV) == 0) begin
        check("strobe_dv", bus_if.duty_valid, 9'd1);
        check("strobe_duty", bus_if.duty_cycle, 9'(seq[idx]));
        m_cur = seq[idx];
        idx++;
        if (!frozen_done && idx == freeze_after && freeze_len > 0) begin
          freeze_left = freeze_len;
          frozen_done = 1'b1;
        end
      end else begin
        check("hold_dv", bus_if.duty_valid, 9'd0);
        check("hold_duty", bus_if.duty_cycle, 9'(m_cur));
      end
      check("busy", busy, 9'(idx < seq.size()));
      check("at_target", at_target, 9'(idx == seq.size()));
      check("ready", bus_if.target_ready, 9'((idx == seq.size()) && en_edge));
    end
    if (idx < seq.size()) check("ramp_timeout", 9'(idx), 9'(seq.size()));
    enable = 1'b1;
    bus_if.target_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    bus_if.target = 8'd0;
    bus_if.target_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_duty", bus_if.duty_cycle, 9'(RESET_DUTY));
    check("rst_dv", bus_if.duty_valid, 9'd0);
    check("rst_busy", busy, 9'd0);
    check("rst_at", at_target, 9'd1);
    rst = 1'b0;
    #1;
    check("rst_ready", bus_if.target_ready, 9'd1);
    enable = 1'b0;
    #1;
    check("ready_gated", bus_if.target_ready, 9'd0);
    enable = 1'b1;

    run_ramp(50, -1, 0, 1'b0);
    run_ramp(99, -1, 0, 1'b0);
    run_ramp(0, -1, 0, 1'b0);
    run_ramp(33, -1, 0, 1'b0);
    run_ramp(33, -1, 0, 1'b0);
    run_ramp(20, -1, 0, 1'b0);
    run_ramp(50, 2, 10, 1'b0);
    run_ramp(20, -1, 0, 1'b0);
    run_ramp(50, -1, 0, 1'b1);

    // Reset in the middle of a ramp toward 80.
    bus_if.target = 8'd80;
    bus_if.target_valid = 1'b1;
    #1;
    check("mid_ready", bus_if.target_ready, 9'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.target_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy, 9'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_duty", bus_if.duty_cycle, 9'(RESET_DUTY));
    check("mid_rst_dv", bus_if.duty_valid, 9'd0);
    check("mid_rst_busy", busy, 9'd0);
    check("mid_rst_at", at_target, 9'd1);
    check("mid_rst_ready", bus_if.target_ready, 9'd1);
    rst = 1'b0;
    m_cur = RESET_DUTY;

    for (int i = 0; i < 8; i++) begin
      int t, fa, fl;
      t  = int'($urandom_range(0, 120));
      fa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      fl = int'($urandom_range(1, 6));
      run_ramp(t, fa, fl, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Upstream feeder for the pwm block. Accepts a target duty cycle over a valid/ready handshake and slews the current duty toward it in fixed steps at a programmable rate (soft-start / slew limiting). Each step is presented as a duty_cycle value with a one-cycle duty_valid strobe, which drives the pwm block's duty_cycle/duty_valid inputs directly. Duty values are percent, 0..100, in 8 bits.

Parameters:
RAMP_DIV, 1000, clock cycles between successive duty steps (>=1)
STEP, 1, duty increment/decrement per step in percent (1..100)
RESET_DUTY, 20, duty value held after reset
MIN_DUTY, 20, lower clamp applied to accepted targets
MAX_DUTY, 80, upper clamp applied to accepted targets
- Legal only when MIN_DUTY <= RESET_DUTY <= MAX_DUTY <= 100. Elaboration-time assertion enforces this.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
enable  input  1  1 = ramp advances; 0 = ramp frozen, no new targets accepted
target  input  8  requested duty, percent
target_valid  input  1  target is valid
target_ready  output  1  block can accept a target
duty_cycle  output  8  current duty presented to pwm, registered
duty_valid  output  1  one-cycle strobe, asserted when duty_cycle updates
busy  output  1  ramp in progress
at_target  output  1  current duty equals last accepted target

Behaviour:
- Reset state, on the first clk edge with rst=1: state IDLE, current=target_reg=RESET_DUTY, duty_cycle=RESET_DUTY, duty_valid=0, busy=0, at_target=1, prescaler=0. target_ready=1 on the first cycle after rst is released, provided enable=1.
- target_ready = (state==IDLE) && enable. It is combinational from state and enable.
- Accept occurs when target_valid && target_ready. The accepted value is clamped into [MIN_DUTY, MAX_DUTY] and stored in target_reg. The prescaler clears to 0.
- After accept, the next state is determined as follows:
  - clamped target > current: RAMP_UP.
  - clamped target < current: RAMP_DOWN.
  - clamped target == current: stay IDLE, no duty_valid.
- States: IDLE, RAMP_UP, RAMP_DOWN. busy=1 in both RAMP states.
- Prescaler runs only in RAMP states with enable=1. It counts 0..RAMP_DIV-1. The wrap cycle is a step tick.
- On each step tick:
  - RAMP_UP: current = min(current+STEP, target_reg).
  - RAMP_DOWN: current = max(current-STEP, target_reg).
  - Arithmetic is done in 9 bits, signed for the down step, so there is no overflow or underflow.
  - duty_cycle takes the new value in the same register update, and duty_valid=1 for exactly that cycle.
- When the stepped value equals target_reg, the next state is IDLE and at_target=1. target_ready rises on the following cycle.
- Latency: the first duty_valid comes RAMP_DIV cycles after the accept edge. Subsequent strobes are spaced RAMP_DIV cycles apart. With RAMP_DIV=1, a strobe occurs every cycle.
- enable=0 during a ramp: the prescaler, state and current are held, and no strobes are issued. Counting resumes from the held prescaler value when enable returns to 1.
- target_valid while busy is ignored, not queued. The upstream source must hold target_valid until it sees target_ready.
- rst mid-ramp: full reset values on the next edge. duty_valid is not asserted for the reset value; the pwm block applies its own reset duty.
- at_target=0 from the accept edge of a differing target until the final step.

Decomposition:
- Shared package pwm_pkg holds:
  - duty_t (logic [7:0]).
  - ramp_state_e enum (IDLE, RAMP_UP, RAMP_DOWN).
  - DUTY_FULL_SCALE=100.
  - Clamp function clamp_duty(value, min, max), shared with the pwm block.
- One sub-module, pwm_ramp_tick: a prescaler with clear/enable inputs and a tick output, parameterised by RAMP_DIV. Reused by the pwm block's CLK_SCALER divider.

Test Plan:
All scenarios use RAMP_DIV=4, STEP=5, RESET_DUTY=20, MIN_DUTY=20, MAX_DUTY=80.
- Reset released -> duty_cycle=20, duty_valid=0, busy=0, at_target=1, target_ready=1.
- Target 50 accepted at cycle T -> strobes at T+4, T+8, … T+24 with values 25, 30, 35, 40, 45, 50 -> IDLE, at_target=1, ready high at T+25.
- Target 99 -> clamped to 80, ramp ends at 80. Then target 0 -> clamped to 20, ramps down 75, 70, … 20.
- Target 33 from 20 -> strobes 25, 30, 33 (final step truncated to target). Target 33 again -> no strobe, stays IDLE.
- enable=0 for 10 cycles after the second strobe of 20->50 -> no strobes, duty_cycle holds 30. After enable returns, strobes resume at the same spacing.
- target_valid=1 with target=70 pulsed while busy -> ignored, ramp still ends at 50. rst asserted mid-ramp -> duty_cycle=20, state IDLE on the next edge.
